// File: rtl/conv_window_gen_pkg.sv
// ============================================================================
// Module   : conv_window_gen_pkg
// Brief    : Shared defaults and 3x3 window index map for the window/conv stages.
// Revision : 1.0
// ============================================================================
`default_nettype none

package conv_window_gen_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int IMG_W_DEF  = 28;
    localparam int IMG_H_DEF  = 28;
    localparam int WIN_N      = 9;

    // Row-major positions inside the 3x3 neighbourhood, shared with the kernel weights.
    localparam int TL = 0;
    localparam int TC = 1;
    localparam int TR = 2;
    localparam int ML = 3;
    localparam int MC = 4;
    localparam int MR = 5;
    localparam int BL = 6;
    localparam int BC = 7;
    localparam int BR = 8;

endpackage

`default_nettype wire

// File: rtl/line_buffer.sv
// ============================================================================
// Module   : line_buffer
// Brief    : DEPTH-deep delay line for pixel rows, advancing only on en.
// Revision : 1.0
// ============================================================================
`default_nettype none

module line_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 28
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    localparam int              PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  ptr_q;
    logic [PTR_W-1:0]  ptr_d;

    // Circular buffer: the slot about to be overwritten holds the sample from DEPTH advances ago.
    assign dout  = mem_q[ptr_q];
    assign ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (en) begin
            ptr_q <= ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            mem_q[ptr_q] <= din;
        end
    end

endmodule

`default_nettype wire

// File: rtl/conv_window_gen.sv
// ============================================================================
// Module   : conv_window_gen
// Brief    : Streaming 3x3 window generator emitting only fully-interior windows.
// Revision : 1.0
// ============================================================================
`default_nettype none

module conv_window_gen
    import conv_window_gen_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [DATA_W-1:0] data0,
    output logic [DATA_W-1:0] data1,
    output logic [DATA_W-1:0] data2,
    output logic [DATA_W-1:0] data3,
    output logic [DATA_W-1:0] data4,
    output logic [DATA_W-1:0] data5,
    output logic [DATA_W-1:0] data6,
    output logic [DATA_W-1:0] data7,
    output logic [DATA_W-1:0] data8
);

    localparam int               COL_W    = $clog2(IMG_W);
    localparam int               ROW_W    = $clog2(IMG_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    logic              accept;
    logic              win_ok;
    logic              frame_end;
    logic [DATA_W-1:0] tap_top;
    logic [DATA_W-1:0] tap_mid;

    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [DATA_W-1:0] win_q [WIN_N];
    logic [DATA_W-1:0] win_d [WIN_N];
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;

    assign in_ready  = !(out_valid_q && !out_ready);
    assign accept    = in_valid && in_ready;
    assign win_ok    = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
    assign frame_end = (row_q == ROW_LAST) && (col_q == COL_LAST);

    line_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_W)
    ) u_lb1 (
        .clk  (clk),
        .rst  (rst),
        .en   (accept),
        .din  (in_data),
        .dout (tap_mid)
    );

    line_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_W)
    ) u_lb2 (
        .clk  (clk),
        .rst  (rst),
        .en   (accept),
        .din  (tap_mid),
        .dout (tap_top)
    );

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        win_d       = win_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        if (accept) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end

            win_d[TL] = win_q[TC];
            win_d[TC] = win_q[TR];
            win_d[TR] = tap_top;
            win_d[ML] = win_q[MC];
            win_d[MC] = win_q[MR];
            win_d[MR] = tap_mid;
            win_d[BL] = win_q[BC];
            win_d[BC] = win_q[BR];
            win_d[BR] = in_data;

            // Accept is only possible when any held window is being consumed this cycle.
            out_valid_d = win_ok;
            out_last_d  = win_ok && frame_end;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            for (int i = 0; i < WIN_N; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            win_q       <= win_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign data0     = win_q[TL];
    assign data1     = win_q[TC];
    assign data2     = win_q[TR];
    assign data3     = win_q[ML];
    assign data4     = win_q[MC];
    assign data5     = win_q[MR];
    assign data6     = win_q[BL];
    assign data7     = win_q[BC];
    assign data8     = win_q[BR];

endmodule

`default_nettype wire

// File: doc/conv_window_gen.md
# conv_window_gen

Streaming 3x3 window generator placed directly upstream of the 3x3 convolution datapath. Accepts one 8-bit pixel per handshake in raster order, buffers the two previous image rows, and presents each fully-interior 3x3 neighbourhood as nine registered pixel outputs (`data0`..`data8`) ready to pair with the nine kernel weights. No padding: an IMG_W x IMG_H frame yields (IMG_W-2)*(IMG_H-2) windows.

## Interface
Parameters:
- DATA_W, 8, pixel width
- IMG_W, 28, pixels per row (>=3)
- IMG_H, 28, rows per frame (>=3)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  pixel present on `in_data`
- in_ready  out  1  block can accept a pixel this cycle
- in_data  in  DATA_W  pixel, raster order
- out_valid  out  1  window valid on `data0`..`data8`
- out_ready  in  1  consumer takes window this cycle
- out_last  out  1  current window is the last of the frame
- data0..data8  out  DATA_W each  window, row-major: data0..2 = row r-2 cols c-2..c; data3..5 = row r-1; data6..8 = row r

## Operation
- Accept = in_valid && in_ready. All state changes only on accept (or output drain).
- in_ready = !(out_valid && !out_ready): a held, unconsumed window stalls input; pass-through when consumer ready.
- Counters col (0..IMG_W-1), row (0..IMG_H-1) mark the position of the accepted pixel. On accept: col++, wrap to 0 at IMG_W-1 with row++; at (IMG_H-1, IMG_W-1) both wrap to 0 (next pixel starts a new frame).
- Two line buffers of IMG_W entries each: lb1 delays the incoming stream by IMG_W accepts, lb2 delays lb1's output by IMG_W accepts. On accept at (r,c): tap_top = lb2 out = pixel(r-2,c), tap_mid = lb1 out = pixel(r-1,c), tap_bot = in_data.
- 3x3 window register: on accept, each row shifts left one column (col0<-col1<-col2), new column (tap_top, tap_mid, tap_bot) enters col2. Outputs driven directly from these registers.
- Window valid when accepted pixel has r>=2 and c>=2. Then out_valid<=1 next cycle; out_last<=1 iff (r,c)=(IMG_H-1, IMG_W-1).
- Accept without a new valid window: out_valid<=0 if out_ready (old window consumed), else not possible (input stalled).
- No accept and out_valid && out_ready: out_valid<=0, out_last<=0.
- Stale line-buffer content at frame start is harmless: rows 0,1 never produce windows; col 0,1 windows never emitted, so cross-row contamination never leaves the block.
- Arithmetic: pure data movement, no width change.

## Timing
- Reset (async assert, sync-released use): col=0, row=0, out_valid=0, out_last=0, data0..data8=0, window registers 0; line-buffer contents need not be cleared (only gated by counters). in_ready=1 after reset.
- Latency: window appears on outputs the cycle after accepting its bottom-right pixel.
- Full throughput: one pixel and one window per cycle with out_ready held high.
- Back-to-back frames: no bubble; first pixel of frame N+1 may be accepted the cycle after the last pixel of frame N.
- Reset mid-frame: counters return to 0; the next accepted pixel is (0,0) of a new frame; any held window is dropped.
- out_valid, data*, out_last stable while out_valid && !out_ready.

## Structure
- Shared package: DATA_W default, IMG_W/IMG_H defaults, window-index constants (TL..BR = 0..8) shared with the conv stage.
- Sub-module `line_buffer` (parameters DATA_W, DEPTH; ports clk, rst, en, din, dout): DEPTH-deep delay line advancing on `en`; instantiated twice. Counters, window registers, handshake in the top.

## Test plan
- IMG_W=4, IMG_H=4, pixels 0..15, out_ready=1 -> 4 windows; first after pixel 10 = {0,1,2,4,5,6,8,9,10}; last = {5,6,7,9,10,11,13,14,15} with out_last=1, others out_last=0.
- Same frame, out_ready low for 3 cycles while first window valid -> in_ready=0 those cycles, window held unchanged, no pixels lost; window sequence identical to case 1.
- Two consecutive frames (pixels 0..15 then 100..115), no gaps -> 8 windows; frame-2 first = {100,101,102,104,105,106,108,109,110}, no window mixes frames.
- Random in_valid gaps (~50%) and random out_ready -> window stream matches golden model exactly, count 4 per frame.
- Assert rst after pixel 9 of a frame, then send a full fresh frame 0..15 -> no window from the aborted frame; outputs match case 1.
- IMG_W=IMG_H=28 default, ramp data mod 256 -> 676 windows, out_last only on the 676th.
